pmu_auth_seq: RTL and testbench

Sequencer for the PMU's lightweight SHA-256 user-authentication unit. It accepts a 32-bit word stream carrying an 8-word expected digest followed by an 8-word message block. It drives the SHA unit's memory-style write port (cs/we/wc/address/write_data) to load both, pulses init, waits a fixed core latency, then samples the unit's digest_valid compare result. It reports pass/fail and enforces a lockout after repeated failures. It sits between the PMU configuration word path and the sha256 authentication wrapper.

---
 rtl/pmu_auth_seq_if.sv | 23 ++
 rtl/pmu_auth_seq.sv | 188 ++++++++++++++++++
 tb/tb_pmu_auth_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pmu_auth_seq_if.sv
// Word-stream and SHA write-port bundle between the PMU config path and the auth sequencer.
// The master modport is the sequencer side; the slave modport is the stream source plus SHA unit.
interface pmu_auth_seq_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        sha_cs;
  logic        sha_we;
  logic        sha_wc;
  logic [2:0]  sha_addr;
  logic [31:0] sha_wdata;
  logic        sha_digest_valid;

  modport master (
    input  s_valid, s_data, sha_digest_valid,
    output s_ready, sha_cs, sha_we, sha_wc, sha_addr, sha_wdata
  );

  modport slave (
    output s_valid, s_data, sha_digest_valid,
    input  s_ready, sha_cs, sha_we, sha_wc, sha_addr, sha_wdata
  );
endinterface

// File: rtl/pmu_auth_seq.sv
// SHA-256 user-authentication sequencer: loads expected digest and message block,
// fires init, waits a fixed latency, publishes pass/fail and enforces a failure lockout.
module pmu_auth_seq #(
  parameter int unsigned CORE_LATENCY = 70,
  parameter int unsigned MAX_FAILS    = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  pmu_auth_seq_if.master bus,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic           fail,
  output logic           locked
);

  localparam int unsigned WCNT_W = $clog2(CORE_LATENCY + 1);
  localparam int unsigned FCNT_W = $clog2(MAX_FAILS + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_DIG = 3'd1,
    S_LOAD_BLK = 3'd2,
    S_INIT     = 3'd3,
    S_WAIT     = 3'd4,
    S_CHECK    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

  logic        s_ready_q, s_ready_d;
  logic        sha_cs_q, sha_cs_d;
  logic        sha_we_q, sha_we_d;
  logic        sha_wc_q, sha_wc_d;
  logic [2:0]  sha_addr_q, sha_addr_d;
  logic [31:0] sha_wdata_q, sha_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        locked_q, locked_d;

  logic accept_s;
  logic start_ok_s;

  assign accept_s   = bus.s_valid & s_ready_q;
  assign start_ok_s = (state_q == S_IDLE) & start & ~locked_q;

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      wcnt_q      <= '0;
      fcnt_q      <= '0;
      s_ready_q   <= 1'b0;
      sha_cs_q    <= 1'b0;
      sha_we_q    <= 1'b0;
      sha_wc_q    <= 1'b0;
      sha_addr_q  <= 3'd0;
      sha_wdata_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      fcnt_q      <= fcnt_d;
      s_ready_q   <= s_ready_d;
      sha_cs_q    <= sha_cs_d;
      sha_we_q    <= sha_we_d;
      sha_wc_q    <= sha_wc_d;
      sha_addr_q  <= sha_addr_d;
      sha_wdata_q <= sha_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      locked_q    <= locked_d;
    end
  end

  // Next-state, word index, wait countdown and consecutive-failure count.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok_s) begin
          state_d = S_LOAD_DIG;
          idx_d   = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_DIG, S_LOAD_BLK: begin
        if (accept_s) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = (state_q == S_LOAD_DIG) ? S_LOAD_BLK : S_INIT;
          end else begin
            state_d = state_q;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_INIT: begin
        state_d = S_WAIT;
        wcnt_d  = WCNT_W'(CORE_LATENCY);
      end
      S_WAIT: begin
        // Stop at zero so the countdown can never wrap.
        if (wcnt_q > WCNT_W'(1)) begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end else begin
          wcnt_d  = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (bus.sha_digest_valid) begin
          fcnt_d = '0;
        end else if (fcnt_q < FCNT_W'(MAX_FAILS)) begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end else begin
          fcnt_d = fcnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    s_ready_d = (state_d == S_LOAD_DIG) || (state_d == S_LOAD_BLK);
    busy_d    = (state_d != S_IDLE);
    sha_we_d  = accept_s;
    sha_cs_d  = (state_q == S_INIT);
    done_d    = (state_q == S_CHECK);
    if (accept_s) begin
      sha_wc_d    = (state_q == S_LOAD_BLK);
      sha_addr_d  = idx_q;
      sha_wdata_d = bus.s_data;
    end else begin
      sha_wc_d    = sha_wc_q;
      sha_addr_d  = sha_addr_q;
      sha_wdata_d = sha_wdata_q;
    end
    if (start_ok_s) begin
      pass_d = 1'b0;
      fail_d = 1'b0;
    end else if (state_q == S_CHECK) begin
      pass_d = bus.sha_digest_valid;
      fail_d = ~bus.sha_digest_valid;
    end else begin
      pass_d = pass_q;
      fail_d = fail_q;
    end
    locked_d = locked_q | ((state_q == S_CHECK) & ~bus.sha_digest_valid &
                           (fcnt_d == FCNT_W'(MAX_FAILS)));
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.sha_cs    = sha_cs_q;
  assign bus.sha_we    = sha_we_q;
  assign bus.sha_wc    = sha_wc_q;
  assign bus.sha_addr  = sha_addr_q;
  assign bus.sha_wdata = sha_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign locked        = locked_q;

endmodule

// File: tb/tb_pmu_auth_seq.sv
// Directed-sequence bench for pmu_auth_seq with random words/gaps, checked against
// a cycle-timeline reference model of the load/init/wait/result and lockout rules.
module tb_pmu_auth_seq;
  localparam int L    = 70;
  localparam int MAXF = 3;

  typedef logic [67:0] wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, pass, fail, locked;

  pmu_auth_seq_if bus();

  pmu_auth_seq #(.CORE_LATENCY(L), .MAX_FAILS(MAXF)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bus    (bus),
    .busy   (busy),
    .done   (done),
    .pass   (pass),
    .fail   (fail),
    .locked (locked)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int overlap = 0;
  int fcnt_m = 0;
  bit locked_m = 1'b0;
  logic [31:0] w [16];
  wr_t wq[$];
  wr_t expw[$];
  int csq[$];
  int dq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write, init strobe and done pulse with its cycle number.
  always @(negedge clk) begin
    if (bus.sha_we === 1'b1) wq.push_back({cyc, bus.sha_wc, bus.sha_addr, bus.sha_wdata});
    if (bus.sha_cs === 1'b1) csq.push_back(cyc);
    if (done === 1'b1) dq.push_back(cyc);
    if (bus.sha_cs === 1'b1 && bus.sha_we === 1'b1) overlap++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {bus.s_ready, bus.sha_cs, bus.sha_we, bus.sha_wc, bus.sha_addr,
              bus.sha_wdata, busy, done, pass, fail, locked}, 72'd0);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    start = 1'b0;
    bus.s_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_zero("reset_hold");
    end
    reset = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");
    fcnt_m   = 0;
    locked_m = 1'b0;
  endtask

  task automatic randw();
    for (int i = 0; i < 16; i++) w[i] = $urandom;
  endtask

  // mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
  task automatic run_auth(input int mode, input bit dv, input bit disturb);
    int t0, k, cl, exp_cs, exp_done, guard;
    bit ph, v;
    wq.delete(); csq.delete(); dq.delete(); expw.delete();
    bus.sha_digest_valid = dv;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    if (locked_m) begin
      repeat (5) begin
        chk("locked_busy", busy, 1'b0);
        chk("locked_ready", bus.s_ready, 1'b0);
        @(negedge clk);
      end
      chk("locked_writes", wq.size(), 0);
      chk("locked_cs", csq.size(), 0);
      chk("locked_fail_hold", {locked, fail, pass}, 3'b110);
      return;
    end
    k = 0; cl = t0; guard = 0; ph = 1'b0;
    while (k < 16 && guard < 400) begin
      chk("load_ready", bus.s_ready, 1'b1);
      chk("load_busy", busy, 1'b1);
      case (mode)
        0:       v = 1'b1;
        1:       v = ph;
        default: v = 1'($urandom_range(0, 1));
      endcase
      ph = ~ph;
      bus.s_valid = v;
      if (v) begin
        bus.s_data = w[k];
        expw.push_back({32'(cyc + 1), (k >= 8), 3'(k % 8), w[k]});
        if (k == 15) cl = cyc;
        k++;
      end else begin
        bus.s_data = $urandom;
      end
      guard++;
      @(negedge clk);
    end
    chk("load_complete", k, 16);
    bus.s_valid = disturb;
    bus.s_data  = $urandom;
    exp_cs   = cl + 2;
    exp_done = cl + 3 + L;
    while (cyc < exp_done) begin
      chk("wait_ready", bus.s_ready, 1'b0);
      chk("wait_busy", busy, 1'b1);
      start = (disturb && cyc == exp_cs + 10);
      @(negedge clk);
    end
    start = 1'b0;
    bus.s_valid = 1'b0;
    if (dv) begin
      fcnt_m = 0;
    end else begin
      if (fcnt_m < MAXF) fcnt_m++;
      if (fcnt_m == MAXF) locked_m = 1'b1;
    end
    chk("done", done, 1'b1);
    chk("pass", pass, dv);
    chk("fail", fail, !dv);
    chk("busy_end", busy, 1'b0);
    chk("locked", locked, locked_m);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("result_hold", {pass, fail}, {dv, !dv});
    chk("n_writes", wq.size(), 16);
    for (int i = 0; i < wq.size() && i < expw.size(); i++) chk("write", wq[i], expw[i]);
    chk("n_cs", csq.size(), 1);
    if (csq.size() > 0) chk("cs_cycle", csq[0], exp_cs);
    chk("n_done", dq.size(), 1);
    if (dq.size() > 0) chk("done_cycle", dq[0], exp_done);
  endtask

  // Start a run and reset it after 8 digest words plus 4 block words.
  task automatic abort_mid_blk();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.s_valid = 1'b1;
    repeat (12) begin
      bus.s_data = $urandom;
      @(negedge clk);
    end
    chk("mid_blk_ready", bus.s_ready, 1'b1);
    reset_dut();
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = 32'd0;
    bus.sha_digest_valid = 1'b0;
    reset_dut();

    for (int i = 0; i < 16; i++) w[i] = 32'(i);
    run_auth(0, 1'b1, 1'b0);
    randw(); run_auth(1, 1'b1, 1'b0);
    randw(); run_auth(2, 1'b0, 1'b0);

    abort_mid_blk();
    randw(); run_auth(0, 1'b1, 1'b0);

    for (int r = 0; r < 3; r++) begin
      randw();
      run_auth((r == 1) ? 2 : 0, 1'b0, 1'b0);
    end
    chk("locked_after_max", locked, 1'b1);
    randw(); run_auth(0, 1'b1, 1'b0);

    reset_dut();
    randw(); run_auth(0, 1'b0, 1'b0);
    randw(); run_auth(1, 1'b0, 1'b0);
    randw(); run_auth(0, 1'b1, 1'b1);
    randw(); run_auth(0, 1'b0, 1'b1);
    chk("not_locked_after_pass", locked, 1'b0);
    chk("cs_we_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
